img_template_capture: RTL and testbench

Captures a 16×16 grey-level template from the camera pixel stream. Each template cell is the mean of a 16×16-pixel block inside a fixed capture window. The block writes the cells into an internal template RAM with 256 entries of 10 bits, in the same cell order and address layout (addr = 16·cellY + cellX) that the template search block reads. It sits beside the search block on the grey pixel path and owns the template contents the search block compares against.

---
 rtl/img_template_pkg.sv | 38 +++
 rtl/template_ram.sv | 35 +++
 rtl/img_template_capture.sv | 194 +++++++++++++++++++
 tb/tb_img_template_capture.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_template_pkg.sv
// img_template_pkg: shared sizes, palette constants, capture state encoding
// and the palette quantiser used by img_template_capture.
package img_template_pkg;

   localparam int GRID      = 16;   // cells per template row / column
   localparam int CELL_LOG2 = 4;    // cell edge is 2**CELL_LOG2 pixels
   localparam int ACC_W     = 18;   // holds 256 * 1023 without overflow
   localparam int PIX_W     = 10;   // grey pixel width
   localparam int ADDR_W    = 8;    // template RAM address width

   localparam logic [PIX_W-1:0] PAL_BLACK = 10'd0;
   localparam logic [PIX_W-1:0] PAL_MID   = 10'd429;
   localparam logic [PIX_W-1:0] PAL_WHITE = 10'd1023;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      CAPTURE = 2'd2
   } captState_t;

   // Map a cell mean onto the three-level search palette.
   function automatic logic [PIX_W-1:0] quantMean(
      input logic [PIX_W-1:0] mean,
      input logic [PIX_W-1:0] loTh,
      input logic [PIX_W-1:0] hiTh
   );
      logic [PIX_W-1:0] q;
      if (mean < loTh) begin
         q = PAL_BLACK;
      end else if (mean < hiTh) begin
         q = PAL_MID;
      end else begin
         q = PAL_WHITE;
      end
      return q;
   endfunction

endpackage

// File: rtl/template_ram.sv
// template_ram: 256 x 10 simple dual-port RAM, one write port and one
// registered read port on a single clock. A read of the address being
// written in the same cycle returns the previous contents. Only the read
// register is reset; the array keeps its contents across reset.
module template_ram
   import img_template_pkg::*;
(
   input  logic              clk,
   input  logic              rstN,
   input  logic              wrEn,
   input  logic [ADDR_W-1:0] wrAddr,
   input  logic [PIX_W-1:0]  wrData,
   input  logic [ADDR_W-1:0] rdAddr,
   output logic [PIX_W-1:0]  rdData
);

   logic [PIX_W-1:0] memR [0:(1<<ADDR_W)-1];

   // Write port: store a finished cell.
   always_ff @(posedge clk) begin
      if (wrEn) begin
         memR[wrAddr] <= wrData;
      end
   end

   // Read port: one-cycle registered read, output register cleared on reset.
   always_ff @(posedge clk) begin
      if (!rstN) begin
         rdData <= {PIX_W{1'b0}};
      end else begin
         rdData <= memR[rdAddr];
      end
   end

endmodule

// File: rtl/img_template_capture.sv
// img_template_capture: builds a 16x16 grey-level template from the pixel
// stream. Each cell is the truncated mean of a 16x16 pixel block inside a
// 256x256 window at (ORIGIN_X, ORIGIN_Y); cells land in template_ram at
// address {cellY, cellX}, the layout the template search block reads.
// Optional feature macro: TEMPLATE_QUANT_EN -- when defined, every written
// mean is quantised to the search palette using LO_TH / HI_TH.
module img_template_capture
   import img_template_pkg::*;
#(
   parameter logic [12:0] ORIGIN_X = 13'd0,
   parameter logic [12:0] ORIGIN_Y = 13'd0
`ifdef TEMPLATE_QUANT_EN
   ,
   parameter logic [9:0]  LO_TH    = 10'd200,
   parameter logic [9:0]  HI_TH    = 10'd800
`endif
)(
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic              iDVAL,
   input  logic [12:0]       iX,
   input  logic [12:0]       iY,
   input  logic [PIX_W-1:0]  iDATA,
   input  logic              iSTART,
   input  logic [ADDR_W-1:0] iRD_ADDR,
   output logic [PIX_W-1:0]  oRD_DATA,
   output logic              oBUSY,
   output logic              oDONE,
   output logic              oVALID,
   output logic              oERR
);

   // Registered pixel
   logic              dvalR;
   logic [12:0]       xR;
   logic [12:0]       yR;
   logic [PIX_W-1:0]  dataR;

   captState_t        stateR;
   logic [ACC_W-1:0]  accR     [GRID];
   logic [ACC_W-1:0]  accNextS [GRID];

   // Pixel decode
   logic [13:0]          diffXS;
   logic [13:0]          diffYS;
   logic                 inWinS;
   logic                 sofS;
   logic                 enterS;
   logic                 procS;
   logic                 finalS;
   logic [CELL_LOG2-1:0] cxS;
   logic [CELL_LOG2-1:0] cyS;
   logic [ACC_W-1:0]     baseS;
   logic [ACC_W-1:0]     sumS;
   logic [PIX_W-1:0]     meanS;
   logic [PIX_W-1:0]     wrDataS;
   logic [ADDR_W-1:0]    wrAddrS;
   logic                 wrEnS;
   logic                 lastWrS;

   // Input stage: register the pixel bus once.
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         dvalR <= 1'b0;
         xR    <= 13'd0;
         yR    <= 13'd0;
         dataR <= 10'd0;
      end else begin
         dvalR <= iDVAL;
         xR    <= iX;
         yR    <= iY;
         dataR <= iDATA;
      end
   end

   // Window test, cell index, running sum and RAM write request.
   always_comb begin
      // One extra bit catches the borrow of pixels left of / above the
      // window; bits [12:8] catch pixels beyond its right / bottom edge.
      diffXS  = {1'b0, xR} - {1'b0, ORIGIN_X};
      diffYS  = {1'b0, yR} - {1'b0, ORIGIN_Y};
      inWinS  = (diffXS[13:8] == 6'd0) && (diffYS[13:8] == 6'd0);
      cxS     = diffXS[7:4];
      cyS     = diffYS[7:4];
      finalS  = (diffXS[3:0] == 4'hF) && (diffYS[3:0] == 4'hF);
      sofS    = dvalR && (xR == 13'd0) && (yR == 13'd0);
      // The SOF that arms the capture is itself a capture pixel; a SOF seen
      // during CAPTURE aborts instead and is not accumulated.
      enterS  = (stateR == ARM) && sofS;
      procS   = dvalR && inWinS && (enterS || ((stateR == CAPTURE) && !sofS));
      if (enterS) begin
         baseS = {ACC_W{1'b0}};
      end else begin
         baseS = accR[cxS];
      end
      sumS    = baseS + {{(ACC_W-PIX_W){1'b0}}, dataR};
      meanS   = PIX_W'(sumS >> (2*CELL_LOG2));
`ifdef TEMPLATE_QUANT_EN
      wrDataS = quantMean(meanS, LO_TH, HI_TH);
`else
      wrDataS = meanS;
`endif
      wrAddrS = {cyS, cxS};
      wrEnS   = procS && finalS;
      lastWrS = wrEnS && (wrAddrS == 8'hFF);
   end

   // Next accumulator values: add the pixel, clear on cell completion,
   // clear everything on entry to CAPTURE.
   always_comb begin
      for (int c = 0; c < GRID; c++) begin
         if (procS && (cxS == CELL_LOG2'(c))) begin
            if (finalS) begin
               accNextS[c] = {ACC_W{1'b0}};
            end else begin
               accNextS[c] = sumS;
            end
         end else if (enterS) begin
            accNextS[c] = {ACC_W{1'b0}};
         end else begin
            accNextS[c] = accR[c];
         end
      end
   end

   // Accumulator bank for the current cell band.
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         for (int c = 0; c < GRID; c++) begin
            accR[c] <= {ACC_W{1'b0}};
         end
      end else begin
         for (int c = 0; c < GRID; c++) begin
            accR[c] <= accNextS[c];
         end
      end
   end

   // Capture sequencer with registered status outputs.
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         stateR <= IDLE;
         oBUSY  <= 1'b0;
         oDONE  <= 1'b0;
         oVALID <= 1'b0;
         oERR   <= 1'b0;
      end else begin
         oDONE <= 1'b0;
         oERR  <= 1'b0;
         case (stateR)
            IDLE: begin
               if (iSTART) begin
                  stateR <= ARM;
                  oBUSY  <= 1'b1;
                  oVALID <= 1'b0;
               end
            end
            ARM: begin
               if (sofS) begin
                  stateR <= CAPTURE;
               end
            end
            CAPTURE: begin
               // The final write takes priority over a coincident SOF.
               if (lastWrS) begin
                  stateR <= IDLE;
                  oBUSY  <= 1'b0;
                  oDONE  <= 1'b1;
                  oVALID <= 1'b1;
               end else if (sofS) begin
                  stateR <= IDLE;
                  oBUSY  <= 1'b0;
                  oERR   <= 1'b1;
               end
            end
            default: begin
               stateR <= IDLE;
               oBUSY  <= 1'b0;
            end
         endcase
      end
   end

   template_ram uRam (
      .clk    (iCLK),
      .rstN   (iRST_N),
      .wrEn   (wrEnS),
      .wrAddr (wrAddrS),
      .wrData (wrDataS),
      .rdAddr (iRD_ADDR),
      .rdData (oRD_DATA)
   );

endmodule

// File: tb/tb_img_template_capture.sv
// tb_img_template_capture: directed bench for img_template_capture with a
// window at (100, 4). Each frame carries, per cell band, the two bottom
// rows of the band (ly[3:0] = 14, 15) across the whole window, framed by
// out-of-window and invalid pixels carrying 1023. A cell therefore sums 32
// pixels and its mean is sum / 256, truncated:
//   mode 0: data 512                  -> 32*512/256 = 64
//   mode 1: data 4*lx                 -> (2048*cx + 960)/256 = 8*cx + 3
//   mode 2: data 64*cy + 4*cx         -> (2048*cy + 128*cx)/256 = 8*cy + cx/2
module tb_img_template_capture;

   localparam int OX = 100;
   localparam int OY = 4;

   logic        iCLK;
   logic        iRST_N;
   logic        iDVAL;
   logic [12:0] iX;
   logic [12:0] iY;
   logic [9:0]  iDATA;
   logic        iSTART;
   logic [7:0]  iRD_ADDR;
   logic [9:0]  oRD_DATA;
   logic        oBUSY;
   logic        oDONE;
   logic        oVALID;
   logic        oERR;

   int checks  = 0;
   int errors  = 0;
   int doneCnt = 0;
   int errCnt  = 0;

   img_template_capture #(
      .ORIGIN_X (13'd100),
      .ORIGIN_Y (13'd4)
   ) dut (
      .iCLK     (iCLK),
      .iRST_N   (iRST_N),
      .iDVAL    (iDVAL),
      .iX       (iX),
      .iY       (iY),
      .iDATA    (iDATA),
      .iSTART   (iSTART),
      .iRD_ADDR (iRD_ADDR),
      .oRD_DATA (oRD_DATA),
      .oBUSY    (oBUSY),
      .oDONE    (oDONE),
      .oVALID   (oVALID),
      .oERR     (oERR)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   // Count status pulses away from the active edge.
   always @(negedge iCLK) begin
      if (oDONE === 1'b1) doneCnt <= doneCnt + 1;
      if (oERR === 1'b1)  errCnt  <= errCnt + 1;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int pixVal(input int mode, input int lx, input int ly);
      case (mode)
         0:       return 512;
         1:       return 4 * lx;
         default: return 64 * (ly / 16) + 4 * (lx / 16);
      endcase
   endfunction

   function automatic int expQ(input int v);
`ifdef TEMPLATE_QUANT_EN
      if (v < 200) return 0;
      else if (v < 800) return 429;
      else return 1023;
`else
      return v;
`endif
   endfunction

   // kind 0..2: full capture of that mode; kind 3: bands 0..6 from mode 2
   // over a mode 1 template (aborted capture).
   function automatic int expCell(input int kind, input int cx, input int cy);
      int v;
      case (kind)
         0:       v = 64;
         1:       v = 8 * cx + 3;
         2:       v = 8 * cy + cx / 2;
         default: v = (cy < 7) ? (8 * cy + cx / 2) : (8 * cx + 3);
      endcase
      return expQ(v);
   endfunction

   task automatic drivePix(input bit v, input int x, input int y, input int d);
      iDVAL = v;
      iX    = 13'(x);
      iY    = 13'(y);
      iDATA = 10'(d);
      @(negedge iCLK);
   endtask

   task automatic pulseStart();
      iSTART = 1'b1;
      @(negedge iCLK);
      iSTART = 1'b0;
   endtask

   // Called one edge after the cell-255 pixel was sampled.
   task automatic checkDoneTiming(input int oldV, input int newV);
      iDVAL = 1'b0;
      checks++;
      if (oDONE !== 1'b0) begin
         errors++; $display("FAIL done_early: oDONE %b expected 0", oDONE);
      end
      iRD_ADDR = 8'd255;
      @(negedge iCLK);
      checks++;
      if (oDONE !== 1'b1 || oVALID !== 1'b1 || oBUSY !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse: done %b valid %b busy %b expected 1 1 0", oDONE, oVALID, oBUSY);
      end
      if (oldV >= 0) begin
         checks++;
         if (oRD_DATA !== 10'(oldV)) begin
            errors++; $display("FAIL rd_same_cycle: got %0d expected old %0d", oRD_DATA, oldV);
         end
      end
      @(negedge iCLK);
      checks++;
      if (oRD_DATA !== 10'(newV) || oDONE !== 1'b0) begin
         errors++;
         $display("FAIL rd_after_write: data %0d done %b expected %0d 0", oRD_DATA, oDONE, newV);
      end
   endtask

   task automatic sendBands(input int mode, input int nBands, input bit chk,
                            input int oldV, input int newV, input bit startMid);
      drivePix(1'b1, 0, 0, 1023);            // SOF, left of the window
      drivePix(1'b1, OX + 20, 1, 1023);      // above the window
      for (int b = 0; b < nBands; b++) begin
         for (int r = 14; r < 16; r++) begin
            for (int x = 0; x < 4; x++) drivePix(1'b1, x, OY + 16 * b + r, 1023);
            drivePix(1'b1, OX - 1, OY + 16 * b + r, 1023);
            for (int lx = 0; lx < 256; lx++) begin
               if (startMid && b == 2 && r == 14 && lx == 0) iSTART = 1'b1;
               drivePix(1'b1, OX + lx, OY + 16 * b + r, pixVal(mode, lx, 16 * b + r));
               iSTART = 1'b0;
               if (chk && b == 15 && r == 15 && lx == 255) checkDoneTiming(oldV, newV);
            end
            drivePix(1'b0, OX + 5, OY + 16 * b + r, 1023);
            drivePix(1'b1, OX + 256, OY + 16 * b + r, 1023);
         end
      end
      iDVAL = 1'b0;
   endtask

   task automatic readAll(input int kind);
      int e;
      for (int a = 0; a < 256; a++) begin
         iRD_ADDR = 8'(a);
         @(negedge iCLK);
         e = expCell(kind, a % 16, a / 16);
         checks++;
         if (oRD_DATA !== 10'(e)) begin
            errors++;
            $display("FAIL rd_kind%0d: addr %0d got %0d expected %0d", kind, a, oRD_DATA, e);
         end
      end
   endtask

   task automatic test_reset();
      iRST_N = 1'b0; iDVAL = 1'b0; iX = 13'd0; iY = 13'd0; iDATA = 10'd0;
      iSTART = 1'b0; iRD_ADDR = 8'd0;
      repeat (3) @(negedge iCLK);
      checks++;
      if (oBUSY !== 1'b0 || oDONE !== 1'b0 || oVALID !== 1'b0 || oERR !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: busy %b done %b valid %b err %b expected 0", oBUSY, oDONE, oVALID, oERR);
      end
      checks++;
      if (oRD_DATA !== 10'd0) begin
         errors++; $display("FAIL reset_rd: got %0d expected 0", oRD_DATA);
      end
      iRST_N = 1'b1;
      @(negedge iCLK);
   endtask

   task automatic test_capture_const();
      int d0;
      int e0;
      d0 = doneCnt; e0 = errCnt;
      pulseStart();
      checks++;
      if (oBUSY !== 1'b1 || oVALID !== 1'b0) begin
         errors++; $display("FAIL arm_busy: busy %b valid %b expected 1 0", oBUSY, oVALID);
      end
      sendBands(0, 16, 1'b1, -1, expQ(64), 1'b0);
      repeat (3) @(negedge iCLK);
      checks++;
      if (doneCnt - d0 != 1 || errCnt != e0) begin
         errors++; $display("FAIL const_pulses: done %0d err %0d expected 1 0", doneCnt - d0, errCnt - e0);
      end
      readAll(0);
   endtask

   task automatic test_ignored_frame();
      int d0;
      d0 = doneCnt;
      sendBands(1, 2, 1'b0, 0, 0, 1'b0);     // frame while IDLE
      repeat (3) @(negedge iCLK);
      checks++;
      if (oVALID !== 1'b1 || oBUSY !== 1'b0 || doneCnt != d0) begin
         errors++;
         $display("FAIL idle_frame: valid %b busy %b done %0d expected 1 0 0", oVALID, oBUSY, doneCnt - d0);
      end
      readAll(0);
   endtask

   task automatic test_offset_capture();
      int d0;
      d0 = doneCnt;
      pulseStart();
      checks++;
      if (oVALID !== 1'b0 || oBUSY !== 1'b1) begin
         errors++; $display("FAIL start_clears_valid: valid %b busy %b expected 0 1", oVALID, oBUSY);
      end
      sendBands(1, 16, 1'b1, expQ(64), expQ(123), 1'b1);
      repeat (3) @(negedge iCLK);
      checks++;
      if (doneCnt - d0 != 1) begin
         errors++; $display("FAIL offset_done: count %0d expected 1", doneCnt - d0);
      end
      readAll(1);
   endtask

   task automatic test_abort();
      int d0;
      int e0;
      d0 = doneCnt; e0 = errCnt;
      pulseStart();
      sendBands(2, 7, 1'b0, 0, 0, 1'b0);     // through row 115
      drivePix(1'b1, 0, 0, 1023);            // second SOF
      iDVAL = 1'b0;
      @(negedge iCLK);
      checks++;
      if (oERR !== 1'b1 || oBUSY !== 1'b0) begin
         errors++; $display("FAIL abort_err: err %b busy %b expected 1 0", oERR, oBUSY);
      end
      repeat (3) @(negedge iCLK);
      checks++;
      if (errCnt - e0 != 1 || doneCnt != d0 || oVALID !== 1'b0 || oBUSY !== 1'b0) begin
         errors++;
         $display("FAIL abort_state: err %0d done %0d valid %b busy %b expected 1 0 0 0",
                  errCnt - e0, doneCnt - d0, oVALID, oBUSY);
      end
      readAll(3);
   endtask

   task automatic test_reset_mid();
      pulseStart();
      sendBands(0, 7, 1'b0, 0, 0, 1'b0);
      iRST_N = 1'b0;
      repeat (2) @(negedge iCLK);
      checks++;
      if (oBUSY !== 1'b0 || oVALID !== 1'b0 || oRD_DATA !== 10'd0) begin
         errors++;
         $display("FAIL reset_mid: busy %b valid %b rd %0d expected 0 0 0", oBUSY, oVALID, oRD_DATA);
      end
      iRST_N = 1'b1;
      @(negedge iCLK);
      pulseStart();
      sendBands(2, 16, 1'b1, expQ(123), expQ(127), 1'b0);
      readAll(2);
   endtask

   initial begin
      test_reset();
      test_capture_const();
      test_ignored_frame();
      test_offset_capture();
      test_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
